// File: rtl/ram8_bank_pkg.sv
// rtl/ram8_bank_pkg.sv - shared sizes, types and load-decode helper for the eight-word register bank
package ram8_bank_pkg;

    localparam int WORD_WIDTH     = 16;
    localparam int RAM8_ADDR_BITS = 3;
    localparam int RAM8_DEPTH     = 8;

    typedef logic [RAM8_ADDR_BITS-1:0] ram8_addr_t;
    typedef logic [RAM8_DEPTH-1:0]     ram8_sel_t;

    // 1-to-8 demultiplexer: routes a single strobe onto the addressed lane only
    function automatic ram8_sel_t demux8(input logic strobe, input ram8_addr_t addr);
        ram8_sel_t sel;
        sel       = '0;
        sel[addr] = strobe;
        return sel;
    endfunction

endpackage

// File: rtl/ram8_bank_if.sv
// rtl/ram8_bank_if.sv - write/read port bundle of the eight-word register bank
interface ram8_bank_if
    import ram8_bank_pkg::*;
#(
    parameter int WIDTH = WORD_WIDTH
);

    logic [WIDTH-1:0] in;
    logic             load;
    ram8_addr_t       address;
    logic [WIDTH-1:0] out;
    ram8_sel_t        written;

    modport master (
        output in,
        output load,
        output address,
        input  out,
        input  written
    );

    modport slave (
        input  in,
        input  load,
        input  address,
        output out,
        output written
    );

endinterface

// File: rtl/ram8_bank_register_w.sv
// rtl/ram8_bank_register_w.sv - WIDTH-bit loadable register with synchronous active-low clear
module register_w #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q;

    // Clear takes priority over load so a write in a reset cycle is dropped
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            q_q <= '0;
        end else if (load_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/ram8_bank.sv
// rtl/ram8_bank.sv - eight WIDTH-bit words with one-hot load routing, mux read and sticky written flags
module ram8_bank
    import ram8_bank_pkg::*;
#(
    parameter int WIDTH = WORD_WIDTH
) (
    input  logic        clock,
    input  logic        reset_n,
    ram8_bank_if.slave  bus
);

    ram8_sel_t        load_sel;
    ram8_sel_t        written_d;
    ram8_sel_t        written_q;
    logic [WIDTH-1:0] word_q [RAM8_DEPTH];

    assign load_sel = demux8(bus.load, bus.address);

    for (genvar g = 0; g < RAM8_DEPTH; g++) begin : g_word
        register_w #(
            .WIDTH (WIDTH)
        ) u_word (
            .clock   (clock),
            .reset_n (reset_n),
            .load_i  (load_sel[g]),
            .d_i     (bus.in),
            .q_o     (word_q[g])
        );
    end

    always_comb begin
        written_d = written_q | load_sel;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            written_q <= '0;
        end else begin
            written_q <= written_d;
        end
    end

    // Read is purely combinational, so a same-cycle write is seen only after the edge
    assign bus.out     = word_q[bus.address];
    assign bus.written = written_q;

endmodule

// File: tb/tb_ram8_bank.sv
// tb/tb_ram8_bank.sv - self-checking bench for ram8_bank: vector table, directed corners, random vs model
module tb_ram8_bank;

    typedef struct {
        logic        rst_n;
        logic        load;
        logic [2:0]  addr;
        logic [15:0] din;
        logic [15:0] exp_out;
        logic [7:0]  exp_wr;
    } vec_t;

    logic clock;
    logic reset_n;
    int   checks;
    int   errors;

    logic [15:0] mdl_mem [8];
    logic [7:0]  mdl_wr;
    vec_t        vecs [9];

    ram8_bank_if #(.WIDTH(16)) bus ();

    ram8_bank #(
        .WIDTH (16)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        if (!reset_n) begin
            for (int k = 0; k < 8; k++) mdl_mem[k] = '0;
            mdl_wr = '0;
        end else if (bus.load) begin
            mdl_mem[bus.address] = bus.in;
            mdl_wr[bus.address]  = 1'b1;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic rst_n, input logic ld, input logic [2:0] a, input logic [15:0] d);
        reset_n     = rst_n;
        bus.load    = ld;
        bus.address = a;
        bus.in      = d;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        for (int i = 0; i < 8; i++) begin
            vecs[i] = '{1'b1, 1'b1, 3'(i), 16'h1000 + 16'(i), 16'h1000 + 16'(i), 8'hFF >> (7 - i)};
        end
        vecs[8] = '{1'b1, 1'b1, 3'd5, 16'hBEEF, 16'hBEEF, 8'hFF};

        // Reset check
        drive(1'b0, 1'b0, 3'd0, 16'h0000);
        tick();
        tick();
        reset_n = 1'b1;
        for (int a = 0; a < 8; a++) begin
            bus.address = 3'(a);
            #1;
            check($sformatf("reset_out[%0d]", a), 32'(bus.out), 32'h0);
        end
        check("reset_written", 32'(bus.written), 32'h0);
        tick();
        check("reset_hold_written", 32'(bus.written), 32'h0);

        // Fill plus isolation write from the vector table
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].rst_n, vecs[i].load, vecs[i].addr, vecs[i].din);
            tick();
            check($sformatf("vec%0d_out", i), 32'(bus.out), 32'(vecs[i].exp_out));
            check($sformatf("vec%0d_written", i), 32'(bus.written), 32'(vecs[i].exp_wr));
        end
        bus.load = 1'b0;
        for (int a = 0; a < 8; a++) begin
            bus.address = 3'(a);
            #1;
            check($sformatf("fill_out[%0d]", a), 32'(bus.out),
                  (a == 5) ? 32'hBEEF : 32'h1000 + 32'(a));
        end

        // Read-before-write at address 2
        drive(1'b1, 1'b1, 3'd2, 16'hCAFE);
        #1;
        check("rbw_before", 32'(bus.out), 32'h1002);
        tick();
        check("rbw_after", 32'(bus.out), 32'hCAFE);

        // Hold at address 6
        drive(1'b1, 1'b0, 3'd6, 16'hFFFF);
        for (int e = 0; e < 4; e++) begin
            tick();
            check($sformatf("hold_out_e%0d", e), 32'(bus.out), 32'h1006);
            check($sformatf("hold_written_e%0d", e), 32'(bus.written), 32'hFF);
        end

        // Reset priority and sticky flag on a zero write
        drive(1'b0, 1'b0, 3'd1, 16'h0000);
        tick();
        drive(1'b1, 1'b1, 3'd1, 16'h0000);
        tick();
        check("zero_write_written", 32'(bus.written), 32'h02);
        check("zero_write_out", 32'(bus.out), 32'h0);
        drive(1'b0, 1'b1, 3'd1, 16'h7777);
        tick();
        check("rst_prio_out", 32'(bus.out), 32'h0);
        check("rst_prio_written", 32'(bus.written), 32'h0);
        drive(1'b1, 1'b0, 3'd1, 16'h7777);
        tick();
        check("post_rst_hold_out", 32'(bus.out), 32'h0);

        // Random traffic against the array model
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 31) != 0), 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)), 16'($urandom));
            #1;
            check("rand_pre", 32'(bus.out), 32'(mdl_mem[bus.address]));
            tick();
            check("rand_post", 32'(bus.out), 32'(mdl_mem[bus.address]));
            check("rand_written", 32'(bus.written), 32'(mdl_wr));
            bus.load    = 1'b0;
            bus.address = 3'($urandom_range(0, 7));
            #1;
            check("rand_peek", 32'(bus.out), 32'(mdl_mem[bus.address]));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram8_bank.md
Name: ram8_bank

Overview:
- Eight-word register memory: the load-routing consumer of the 1-to-8 demultiplexer stage.
- A 3-bit address steers a single load strobe to exactly one of eight WIDTH-bit registers.
- The same address selects, through an 8-way mux, which register drives the read port.
- It is the first storage stage of the memory hierarchy; RAM64 and larger memories are built from instances of it.

Parameters:
- WIDTH, 16, data word width in bits.

Ports:
- clock  input  1  rising-edge system clock.
- reset_n  input  1  synchronous, active-low reset; sampled on the clock rising edge.
- in  input  WIDTH  write data.
- load  input  1  write strobe; when high, in is written to the addressed word at the next rising edge.
- address  input  3  word select, shared by the write and read paths.
- out  output  WIDTH  contents of the addressed word (combinational read).
- written  output  8  sticky per-word flag; bit k is set once word k has been written since the last reset.

Behaviour:
- One clock; reset is synchronous and active-low.
  - A rising edge of clock with reset_n=0 clears all 8 words to 0 and clears written to 8'h00.
  - load is ignored during reset.
- Reset values:
  - All words are 0, so out=0 for any address.
  - written=8'h00.
- Write: a rising edge with reset_n=1 and load=1 performs two updates.
  - word[address] <= in.
  - written[address] <= 1.
  - All other words and written bits hold.
- Load routing is one-hot: exactly one word's enable is asserted, equal to load demuxed by address. No other word may change.
- Hold: a rising edge with load=0 changes no word and no written bit.
- Read:
  - out = word[address] combinationally, with zero latency on address change.
  - A word written at edge N appears on out only after edge N.
  - Before that edge, out shows the old contents, even when load=1 and address matches (read-before-write within the cycle).
- written bits are sticky.
  - Rewriting a word keeps its bit at 1.
  - Writing the value 0 still sets the bit.
  - Only reset clears the bits.
- Simultaneous reset_n=0 and load=1: reset wins; no word takes in.
- Reset mid-sequence: a reset asserted on any edge discards all prior contents. The first edge after reset_n returns high behaves as a normal write or hold.
- Wrap-around: not applicable. All 3-bit addresses are valid and there is no out-of-range case.
- X/unknown address with load=1 is illegal stimulus and the behaviour is undefined; the bench must not drive it.

Decomposition:
- Shared package:
  - WORD_WIDTH = 16.
  - RAM8_ADDR_BITS = 3.
  - RAM8_DEPTH = 8.
- Sub-module register_w (WIDTH-bit loadable register with synchronous active-low clear), instantiated 8 times.
- Load decode uses the existing 1-to-8 demultiplexer.
- Read select uses the existing 8-way WIDTH-bit multiplexer.
- The written flags are a local 8-bit register inside ram8_bank.

Test Plan:
- Reset check:
  - Stimulus: reset_n=0 for 2 edges, then reset_n=1; sweep address 0..7 with load=0.
  - Required: out=16'h0000 for every address, written=8'h00.
- Fill and readback:
  - Stimulus: write word k = 16'h1000+k for k=0..7, one per edge.
  - Required: sweeping address 0..7 reads 16'h1000..16'h1007; written=8'hFF.
- Isolation:
  - Stimulus: after the fill, load=1, address=3'b101, in=16'hBEEF for one edge.
  - Required: address 5 reads 16'hBEEF; the other 7 words are unchanged.
- Read-before-write:
  - Stimulus: address=2 holding 16'h1002; set in=16'hCAFE, load=1.
  - Required: out=16'h1002 before the edge and 16'hCAFE after it.
- Hold:
  - Stimulus: load=0, in=16'hFFFF, 4 edges at address 6.
  - Required: out stays 16'h1006; written unchanged.
- Reset priority and sticky flags:
  - Stimulus: write 16'h0000 to word 1 after reset.
  - Required: written=8'h02.
  - Stimulus: then reset_n=0 with load=1, address=1, in=16'h7777.
  - Required: word 1 reads 16'h0000, written=8'h00.
